// File: rtl/c17_resp_checker_pkg.sv
// Shared definitions for the c17 response path: FSM encoding, default widths
// and the bit ordering of the G6gat/G7gat response pair.
package c17_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DEF_OUT_W = 2;
    localparam int          DEF_SIG_W = 16;
    localparam int          DEF_CNT_W = 16;
    localparam logic [15:0] DEF_POLY  = 16'hB400;
    localparam logic [15:0] DEF_SEED  = 16'h0000;

    // Response vector bit positions shared with the upstream pattern source.
    localparam int G6_BIT = 0;
    localparam int G7_BIT = 1;

endpackage

// File: rtl/c17_resp_checker_if.sv
// Response stream from the circuit under test: one (dut, gold) pair per beat.
interface c17_resp_checker_if
    import c17_tb_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W
) ();

    logic             vec_valid;
    logic             vec_ready;
    logic [OUT_W-1:0] dut_out;
    logic [OUT_W-1:0] gold_out;

    modport master (
        output vec_valid,
        output dut_out,
        output gold_out,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  dut_out,
        input  gold_out,
        output vec_ready
    );

endinterface

// File: rtl/c17_resp_checker_misr.sv
// Galois-form multiple-input signature register compacting CUT responses.
module misr_reg
    import c17_tb_pkg::*;
#(
    parameter int               SIG_W   = DEF_SIG_W,
    parameter int               DIN_W   = DEF_OUT_W,
    parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
    parameter logic [SIG_W-1:0] RST_VAL = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                   input logic [DIN_W-1:0] d);
        logic [SIG_W-1:0] shifted;
        shifted = {cur[SIG_W-2:0], 1'b0};
        if (cur[SIG_W-1]) begin
            shifted = shifted ^ POLY;
        end
        return shifted ^ SIG_W'(d);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= RST_VAL;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= misr_step(sig, din);
        end
    end

endmodule

// File: rtl/c17_resp_checker.sv
// Response checker: counts accepted c17 responses, tracks mismatches against
// the golden response and compacts the CUT outputs into a MISR signature.
module c17_resp_checker
    import c17_tb_pkg::*;
#(
    parameter int               OUT_W = DEF_OUT_W,
    parameter int               SIG_W = DEF_SIG_W,
    parameter int               CNT_W = DEF_CNT_W,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_vectors,
    c17_resp_checker_if.slave    vec,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     vec_idx,
    output logic [CNT_W-1:0]     err_count,
    output logic                 first_err_valid,
    output logic [CNT_W-1:0]     first_err_idx,
    output logic [SIG_W-1:0]     signature
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count_q;
    logic             load;
    logic             accept;
    logic             last_accept;
    logic             mismatch;

    assign vec.vec_ready = (state == RUN);
    assign busy          = (state == RUN);
    assign done          = (state == DONE);
    assign accept        = vec.vec_valid & vec.vec_ready;
    assign mismatch      = (vec.dut_out != vec.gold_out);
    // count_q is never zero in RUN, so count_q-1 cannot wrap.
    assign last_accept   = accept && (vec_idx == count_q - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = (num_vectors != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_accept) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q         <= '0;
            vec_idx         <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (load) begin
            count_q         <= num_vectors;
            vec_idx         <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (accept) begin
            vec_idx <= vec_idx + ONE;
            if (mismatch) begin
                err_count <= err_count + ONE;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= vec_idx;
                end
            end
        end
    end

    misr_reg #(
        .SIG_W   (SIG_W),
        .DIN_W   (OUT_W),
        .POLY    (POLY),
        .RST_VAL (SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .seed  (SEED),
        .en    (accept),
        .din   (vec.dut_out),
        .sig   (signature)
    );

endmodule

// File: tb/tb_c17_resp_checker.sv
// Scoreboard bench for c17_resp_checker: directed scenarios plus random runs.
module tb_c17_resp_checker;
    import c17_tb_pkg::*;

    localparam logic [15:0] POLY = 16'hB400;
    localparam logic [15:0] SEED = 16'h0000;

    typedef struct {
        logic [15:0] idx;
        logic [15:0] err;
        logic        fev;
        logic [15:0] fei;
        logic [15:0] sig;
        logic        dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vectors;
    logic        busy;
    logic        done;
    logic [15:0] vec_idx;
    logic [15:0] err_count;
    logic        first_err_valid;
    logic [15:0] first_err_idx;
    logic [15:0] signature;

    int errors = 0;
    int checks = 0;

    exp_t expq[$];
    logic pending = 1'b0;

    // Reference model state
    int          m_n;
    int          m_idx;
    int          m_err;
    logic        m_fev;
    int          m_fei;
    logic [15:0] m_sig;

    c17_resp_checker_if #(.OUT_W(2)) vec ();

    c17_resp_checker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .num_vectors     (num_vectors),
        .vec             (vec),
        .busy            (busy),
        .done            (done),
        .vec_idx         (vec_idx),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_idx   (first_err_idx),
        .signature       (signature)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signature as polynomial arithmetic over GF(2): sig*x mod (x^16 + POLY), plus data.
    function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [1:0] d);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t = t ^ {1'b1, POLY};
        return t[15:0] ^ {14'd0, d};
    endfunction

    // Monitor: an accept seen before edge N is checked at the negedge after it.
    always @(negedge clk) begin
        exp_t e;
        if (pending) begin
            if (expq.size() == 0) begin
                check("unexpected_accept", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                check("sb_vec_idx", vec_idx, e.idx);
                check("sb_err_count", err_count, e.err);
                check("sb_first_err_valid", first_err_valid, e.fev);
                if (e.fev) check("sb_first_err_idx", first_err_idx, e.fei);
                check("sb_signature", signature, e.sig);
                check("sb_done", done, e.dn);
            end
        end
        pending = rst_n && vec.vec_valid && vec.vec_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start       = 1'b1;
        num_vectors = 16'(n);
        tick();
        start = 1'b0;
        m_n = n; m_idx = 0; m_err = 0; m_fev = 1'b0; m_fei = 0; m_sig = SEED;
        check("start_busy", busy, (n != 0));
        check("start_done", done, (n == 0));
        check("start_ready", vec.vec_ready, (n != 0));
        check("start_vec_idx", vec_idx, 0);
        check("start_err_count", err_count, 0);
        check("start_first_err_valid", first_err_valid, 0);
        check("start_signature", signature, SEED);
    endtask

    // gap idle cycles (optionally poking start while running), then one response beat.
    task automatic send(input logic [1:0] d, input logic [1:0] g, input int gap, input bit poke);
        exp_t e;
        for (int i = 0; i < gap; i++) begin
            if (poke && i == 0) begin
                start       = 1'b1;
                num_vectors = 16'($urandom_range(1, 5));
            end
            tick();
            start = 1'b0;
        end
        vec.vec_valid = 1'b1;
        vec.dut_out   = d;
        vec.gold_out  = g;
        if (d != g) begin
            if (!m_fev) begin
                m_fev = 1'b1;
                m_fei = m_idx;
            end
            m_err++;
        end
        m_idx++;
        m_sig = misr_model(m_sig, d);
        e.idx = 16'(m_idx); e.err = 16'(m_err); e.fev = m_fev;
        e.fei = 16'(m_fei); e.sig = m_sig; e.dn = (m_idx == m_n);
        expq.push_back(e);
        if (m_idx == m_n) check("pre_last_done", done, 0);
        tick();
        vec.vec_valid = 1'b0;
        if (m_idx == m_n) begin
            check("last_done", done, 1);
            check("last_ready", vec.vec_ready, 0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, vec.vec_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_first_err_valid"}, first_err_valid, 0);
        check({tag, "_vec_idx"}, vec_idx, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_first_err_idx"}, first_err_idx, 0);
        check({tag, "_signature"}, signature, SEED);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] d;
        logic [1:0] g;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        num_vectors = '0;
        vec.vec_valid = 1'b0;
        vec.dut_out   = '0;
        vec.gold_out  = '0;
        #12;
        check_reset_state("por");
        rst_n = 1'b1;
        tick();

        // Signature walk: 01 then 10 returns to zero.
        do_start(2);
        send(2'b01, 2'b01, 0, 0);
        check("sig_first", signature, 16'h0001);
        send(2'b10, 2'b10, 0, 0);
        check("sig_second", signature, 16'h0000);
        check("sig_err_count", err_count, 0);
        tick();

        // Mismatches at indices 2 and 4.
        do_start(6);
        for (int i = 0; i < 6; i++) begin
            d = 2'($urandom_range(0, 3));
            g = (i == 2 || i == 4) ? (d ^ 2'b10) : d;
            send(d, g, 0, 0);
        end
        check("mm_err_count", err_count, 2);
        check("mm_first_err_valid", first_err_valid, 1);
        check("mm_first_err_idx", first_err_idx, 2);
        check("mm_vec_idx", vec_idx, 6);
        tick();
        check("mm_done_held", done, 1);

        // Back-to-back from DONE: previous first_err must not survive.
        do_start(1);
        send(2'b11, 2'b11, 0, 0);
        check("b2b_signature", signature, 16'h0003);
        check("b2b_first_err_valid", first_err_valid, 0);
        check("b2b_vec_idx", vec_idx, 1);

        // Stalls with start poked mid-run.
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            d = 2'($urandom_range(0, 3));
            send(d, d, (i == 0) ? 0 : $urandom_range(1, 3), (i != 0));
        end
        check("stall_vec_idx", vec_idx, 4);
        tick();
        check("stall_vec_idx_held", vec_idx, 4);

        // Zero-length run.
        do_start(0);
        for (int i = 0; i < 3; i++) begin
            vec.vec_valid = 1'b1;
            tick();
            check("zero_ready", vec.vec_ready, 0);
            check("zero_vec_idx", vec_idx, 0);
        end
        vec.vec_valid = 1'b0;
        check("zero_err_count", err_count, 0);
        check("zero_signature", signature, SEED);

        // Random runs.
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 12);
            do_start(n);
            for (int k = 0; k < n; k++) begin
                d = 2'($urandom_range(0, 3));
                g = ($urandom_range(0, 3) == 0) ? (d ^ 2'($urandom_range(1, 3))) : d;
                send(d, g, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
            end
            check("rnd_vec_idx", vec_idx, n);
            check("rnd_err_count", err_count, m_err);
            tick();
        end

        // Asynchronous reset in the middle of a run.
        do_start(8);
        for (int i = 0; i < 3; i++) begin
            d = 2'($urandom_range(0, 3));
            send(d, d, 0, 0);
        end
        tick();
        check("mid_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        #2;
        rst_n = 1'b1;
        tick();
        check("midrst_idle_busy", busy, 0);
        tick();

        check("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
